sha256_mem_responder: RTL and testbench

Memory-side responder and run controller for the simplified SHA-256 engine.
- Owns a single-port word RAM and serves the engine's mem_addr/mem_we/mem_write_data/mem_read_data port.
- Gives a host port for loading the message and reading back the digest.
- Sequences one hash run: drives the engine's start, message_addr and output_addr; watches done; counts digest writes; raises irq.

---
 rtl/sha256_mem_pkg.sv | 29 ++
 rtl/sha256_mem_responder_if.sv | 34 +++
 rtl/sha256_word_ram.sv | 46 ++++
 rtl/sha256_mem_responder.sv | 190 +++++++++++++++++++
 tb/tb_sha256_mem_responder.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sha256_mem_pkg.sv
// sha256_mem_pkg: shared types and helpers for the SHA-256 memory responder.
//   state_e       run-controller states
//   OOB_DATA_DEF  default read value for out-of-range word addresses
//   DIGEST_WORDS  number of digest words the engine writes per run
//   addr_ok()     address lies inside a RAM of the given depth
//   in_window()   address lies inside the digest window starting at base
package sha256_mem_pkg;

  typedef enum logic [1:0] {
    ST_HOST = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [31:0] OOB_DATA_DEF = 32'hDEADBEEF;
  localparam int          DIGEST_WORDS = 8;

  function automatic logic addr_ok(input logic [15:0] a, input int depth);
    return {16'd0, a} < 32'(depth);
  endfunction

  // 17-bit compare so a base near 0xFFFF does not wrap the window.
  function automatic logic in_window(input logic [15:0] a, input logic [15:0] base);
    return ({1'b0, a} >= {1'b0, base}) &&
           ({1'b0, a} <= ({1'b0, base} + 17'(DIGEST_WORDS - 1)));
  endfunction

endpackage

// File: rtl/sha256_mem_responder_if.sv
// sha256_mem_responder_if: engine memory port + host access port.
//   engine side : mem_we, mem_addr, mem_write_data -> mem_read_data
//   host side   : host_req, host_we, host_addr, host_wdata ->
//                 host_gnt, host_rdata, host_rvalid
//   slave  modport: the responder
//   master modport: engine/host requesters
interface sha256_mem_responder_if;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic        host_req;
  logic        host_we;
  logic [15:0] host_addr;
  logic [31:0] host_wdata;
  logic        host_gnt;
  logic [31:0] host_rdata;
  logic        host_rvalid;

  modport slave (
    input  mem_we, mem_addr, mem_write_data,
    output mem_read_data,
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rdata, host_rvalid
  );

  modport master (
    output mem_we, mem_addr, mem_write_data,
    input  mem_read_data,
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rdata, host_rvalid
  );
endinterface

// File: rtl/sha256_word_ram.sv
// sha256_word_ram: DEPTH x 32 word RAM, one write port, two registered
// read ports (A: engine, free-running; B: host, enabled per read).
//   clk, reset_n      clock, async active-low reset (read registers only)
//   we_i/waddr_i/wdata_i  write port; out-of-range writes are dropped
//   a_addr_i/a_rdata_o    port A, updated every cycle
//   b_en_i/b_addr_i/b_rdata_o  port B, updated only when b_en_i
// Out-of-range reads return OOB_DATA. Reads see the pre-write contents.
module sha256_word_ram
  import sha256_mem_pkg::*;
#(
  parameter int          DEPTH    = 256,
  parameter logic [31:0] OOB_DATA = OOB_DATA_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        we_i,
  input  logic [15:0] waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [15:0] a_addr_i,
  output logic [31:0] a_rdata_o,
  input  logic        b_en_i,
  input  logic [15:0] b_addr_i,
  output logic [31:0] b_rdata_o
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] a_q, b_q;

  // Array is intentionally not reset: contents survive reset_n.
  always_ff @(posedge clk)
    if (we_i && addr_ok(waddr_i, DEPTH)) mem_q[waddr_i[AW-1:0]] <= wdata_i;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= addr_ok(a_addr_i, DEPTH) ? mem_q[a_addr_i[AW-1:0]] : OOB_DATA;
      if (b_en_i)
        b_q <= addr_ok(b_addr_i, DEPTH) ? mem_q[b_addr_i[AW-1:0]] : OOB_DATA;
    end

  assign a_rdata_o = a_q;
  assign b_rdata_o = b_q;
endmodule

// File: rtl/sha256_mem_responder.sv
// sha256_mem_responder: owns the word RAM for the SHA-256 engine, serves the
// host load/readback port and sequences one hash run.
//   clk, reset_n          clock (engine mem_clk domain), async active-low reset
//   bus (slave)           engine mem port + host access port
//   eng_start             one-cycle start pulse to the engine
//   eng_done              engine idle/done level
//   message_addr/output_addr  bases latched at kick
//   host_kick/host_msg_addr/host_out_addr  start a run
//   host_ack              clears irq and error flags, returns to HOST
//   irq, err_timeout, err_short, err_oob   run status
//   digest_cnt            digest-window writes seen in this run
//   run_cycles            cycles spent in RUN
module sha256_mem_responder
  import sha256_mem_pkg::*;
#(
  parameter int          DEPTH       = 256,
  parameter int          ARM_TIMEOUT = 16,
  parameter logic [31:0] OOB_DATA    = OOB_DATA_DEF
) (
  input  logic                         clk,
  input  logic                         reset_n,
  sha256_mem_responder_if.slave        bus,
  output logic                         eng_start,
  input  logic                         eng_done,
  output logic [15:0]                  message_addr,
  output logic [15:0]                  output_addr,
  input  logic                         host_kick,
  input  logic [15:0]                  host_msg_addr,
  input  logic [15:0]                  host_out_addr,
  input  logic                         host_ack,
  output logic                         irq,
  output logic                         err_timeout,
  output logic                         err_short,
  output logic                         err_oob,
  output logic [3:0]                   digest_cnt,
  output logic [31:0]                  run_cycles
);
  state_e      state_q, state_d;
  logic        start_q, start_d;
  logic [15:0] msg_q, msg_d, out_q, out_d;
  logic        irq_q, irq_d, err_t_q, err_t_d, err_s_q, err_s_d, err_o_q, err_o_d;
  logic [3:0]  dcnt_q, dcnt_d;
  logic [31:0] run_q, run_d;
  logic [15:0] arm_q, arm_d;
  logic        done_q;
  logic        rvalid_q;

  logic        in_run, host_gnt, host_rd, host_wr, eng_wr, host_oob, eng_oob, win_hit;
  logic        ram_we;
  logic [15:0] ram_waddr;
  logic [31:0] ram_wdata;

  assign in_run   = (state_q == ST_RUN);
  assign host_gnt = bus.host_req && !in_run;
  assign host_rd  = host_gnt && !bus.host_we;
  assign host_wr  = host_gnt && bus.host_we;
  // Engine writes outside RUN are dropped; the engine read port is live every cycle.
  assign eng_wr   = in_run && bus.mem_we;
  assign host_oob = host_gnt && !addr_ok(bus.host_addr, DEPTH);
  // Engine addresses only matter while it owns the RAM.
  assign eng_oob  = in_run && !addr_ok(bus.mem_addr, DEPTH);
  assign win_hit  = eng_wr && in_window(bus.mem_addr, out_q);

  // Host and engine writes are exclusive by state, so a plain mux suffices.
  assign ram_we    = eng_wr || host_wr;
  assign ram_waddr = eng_wr ? bus.mem_addr       : bus.host_addr;
  assign ram_wdata = eng_wr ? bus.mem_write_data : bus.host_wdata;

  sha256_word_ram #(.DEPTH(DEPTH), .OOB_DATA(OOB_DATA)) u_ram (
    .clk       (clk),
    .reset_n   (reset_n),
    .we_i      (ram_we),
    .waddr_i   (ram_waddr),
    .wdata_i   (ram_wdata),
    .a_addr_i  (bus.mem_addr),
    .a_rdata_o (bus.mem_read_data),
    .b_en_i    (host_rd),
    .b_addr_i  (bus.host_addr),
    .b_rdata_o (bus.host_rdata)
  );

  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    msg_d   = msg_q;
    out_d   = out_q;
    irq_d   = irq_q;
    err_t_d = err_t_q;
    err_s_d = err_s_q;
    err_o_d = err_o_q | host_oob | eng_oob;
    dcnt_d  = dcnt_q;
    run_d   = run_q;
    arm_d   = arm_q;
    unique case (state_q)
      ST_HOST: begin
        if (host_ack) begin
          irq_d   = 1'b0;
          err_t_d = 1'b0;
          err_s_d = 1'b0;
          err_o_d = host_oob;
        end
        // A busy engine cannot accept a start, so the kick is dropped.
        if (host_kick && eng_done) begin
          msg_d   = host_msg_addr;
          out_d   = host_out_addr;
          start_d = 1'b1;
          dcnt_d  = '0;
          run_d   = '0;
          arm_d   = '0;
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        if (!eng_done) begin
          state_d = ST_RUN;
        end else if (arm_q == 16'(ARM_TIMEOUT - 1)) begin
          err_t_d = 1'b1;
          irq_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          arm_d = arm_q + 16'd1;
        end
      end
      ST_RUN: begin
        if (run_q != '1) run_d = run_q + 32'd1;
        if (win_hit && dcnt_q != 4'hF) dcnt_d = dcnt_q + 4'd1;
        // dcnt_d includes a digest write landing on the done edge.
        if (eng_done && !done_q) begin
          irq_d   = 1'b1;
          err_s_d = (dcnt_d != 4'(DIGEST_WORDS));
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // Kick is ignored here; ack alone moves us on.
        if (host_ack) begin
          irq_d   = 1'b0;
          err_t_d = 1'b0;
          err_s_d = 1'b0;
          err_o_d = host_oob;
          state_d = ST_HOST;
        end
      end
      default: state_d = ST_HOST;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q  <= ST_HOST;
      start_q  <= 1'b0;
      msg_q    <= '0;
      out_q    <= '0;
      irq_q    <= 1'b0;
      err_t_q  <= 1'b0;
      err_s_q  <= 1'b0;
      err_o_q  <= 1'b0;
      dcnt_q   <= '0;
      run_q    <= '0;
      arm_q    <= '0;
      done_q   <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      msg_q    <= msg_d;
      out_q    <= out_d;
      irq_q    <= irq_d;
      err_t_q  <= err_t_d;
      err_s_q  <= err_s_d;
      err_o_q  <= err_o_d;
      dcnt_q   <= dcnt_d;
      run_q    <= run_d;
      arm_q    <= arm_d;
      done_q   <= eng_done;
      rvalid_q <= host_rd;
    end

  assign bus.host_gnt    = host_gnt;
  assign bus.host_rvalid = rvalid_q;
  assign eng_start       = start_q;
  assign message_addr    = msg_q;
  assign output_addr     = out_q;
  assign irq             = irq_q;
  assign err_timeout     = err_t_q;
  assign err_short       = err_s_q;
  assign err_oob         = err_o_q;
  assign digest_cnt      = dcnt_q;
  assign run_cycles      = run_q;
endmodule

// File: tb/tb_sha256_mem_responder.sv
module tb_sha256_mem_responder;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        eng_start, eng_done;
  logic [15:0] message_addr, output_addr;
  logic        host_kick, host_ack;
  logic [15:0] host_msg_addr, host_out_addr;
  logic        irq, err_timeout, err_short, err_oob;
  logic [3:0]  digest_cnt;
  logic [31:0] run_cycles;

  sha256_mem_responder_if bus_if();

  sha256_mem_responder #(.DEPTH(256), .ARM_TIMEOUT(16), .OOB_DATA(32'hDEADBEEF)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus           (bus_if),
    .eng_start     (eng_start),
    .eng_done      (eng_done),
    .message_addr  (message_addr),
    .output_addr   (output_addr),
    .host_kick     (host_kick),
    .host_msg_addr (host_msg_addr),
    .host_out_addr (host_out_addr),
    .host_ack      (host_ack),
    .irq           (irq),
    .err_timeout   (err_timeout),
    .err_short     (err_short),
    .err_oob       (err_oob),
    .digest_cnt    (digest_cnt),
    .run_cycles    (run_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        exp_gnt;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sb[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One host access: grant checked combinationally, read expectation queued,
  // then popped against host_rdata when host_rvalid is due.
  task automatic run_vec(input vec_t v);
    logic        exp_rv;
    logic [31:0] e;
    bus_if.host_req   = 1'b1;
    bus_if.host_we    = v.we;
    bus_if.host_addr  = v.addr;
    bus_if.host_wdata = v.wdata;
    #1;
    chk("host_gnt", {31'd0, bus_if.host_gnt}, {31'd0, v.exp_gnt});
    if (v.exp_gnt && !v.we) sb.push_back(v.exp_rdata);
    tick();
    bus_if.host_req = 1'b0;
    exp_rv = (sb.size() > 0);
    chk("host_rvalid", {31'd0, bus_if.host_rvalid}, {31'd0, exp_rv});
    if (exp_rv) begin
      e = sb.pop_front();
      if (bus_if.host_rvalid) chk("host_rdata", bus_if.host_rdata, e);
    end
  endtask

  function automatic vec_t rd(input logic [15:0] a, input logic [31:0] e);
    vec_t v;
    v.we = 1'b0; v.addr = a; v.wdata = '0; v.exp_gnt = 1'b1; v.exp_rdata = e;
    return v;
  endfunction

  function automatic vec_t wr(input logic [15:0] a, input logic [31:0] d);
    vec_t v;
    v.we = 1'b1; v.addr = a; v.wdata = d; v.exp_gnt = 1'b1; v.exp_rdata = '0;
    return v;
  endfunction

  task automatic kick(input logic [15:0] m, input logic [15:0] o);
    host_msg_addr = m;
    host_out_addr = o;
    host_kick     = 1'b1;
    tick();
    host_kick = 1'b0;
  endtask

  task automatic ack();
    host_ack = 1'b1;
    tick();
    host_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n = 1'b0;
    eng_done = 1'b1;
    host_kick = 1'b0; host_ack = 1'b0; host_msg_addr = '0; host_out_addr = '0;
    bus_if.mem_we = 1'b0; bus_if.mem_addr = '0; bus_if.mem_write_data = '0;
    bus_if.host_req = 1'b0; bus_if.host_we = 1'b0; bus_if.host_addr = '0; bus_if.host_wdata = '0;
    #3;
    chk("rst irq", {31'd0, irq}, 32'd0);
    chk("rst eng_start", {31'd0, eng_start}, 32'd0);
    chk("rst errs", {29'd0, err_timeout, err_short, err_oob}, 32'd0);
    chk("rst digest_cnt", {28'd0, digest_cnt}, 32'd0);
    chk("rst run_cycles", run_cycles, 32'd0);
    chk("rst mem_read_data", bus_if.mem_read_data, 32'd0);
    chk("rst host_rvalid", {31'd0, bus_if.host_rvalid}, 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // 1: load message words, read some back
    for (int i = 0; i < 20; i++) vecs.push_back(wr(16'(i), 32'(i + 1)));
    vecs.push_back(rd(16'h0005, 32'h0000_0006));
    vecs.push_back(rd(16'h0013, 32'h0000_0014));
    vecs.push_back(rd(16'h0000, 32'h0000_0001));
    foreach (vecs[i]) run_vec(vecs[i]);

    // 2 + 3: full run, host read held off during RUN
    kick(16'h0000, 16'h0020);
    chk("t2 eng_start", {31'd0, eng_start}, 32'd1);
    chk("t2 message_addr", {16'd0, message_addr}, 32'h0000);
    chk("t2 output_addr", {16'd0, output_addr}, 32'h0020);
    eng_done = 1'b0;
    tick();
    chk("t2 start pulse", {31'd0, eng_start}, 32'd0);
    bus_if.host_req = 1'b1; bus_if.host_we = 1'b0; bus_if.host_addr = 16'h0003;
    for (int i = 0; i < 20; i++) begin
      bus_if.mem_addr = 16'(i);
      #1 chk("t3 gnt in run", {31'd0, bus_if.host_gnt}, 32'd0);
      tick();
      chk("t2 mem_read_data", bus_if.mem_read_data, 32'(i + 1));
    end
    for (int i = 0; i < 8; i++) begin
      bus_if.mem_we = 1'b1;
      bus_if.mem_addr = 16'h0020 + 16'(i);
      bus_if.mem_write_data = 32'hA000_0000 + 32'(i);
      if (i == 7) eng_done = 1'b1;  // last digest word lands with done rising
      #1 chk("t3 gnt in run", {31'd0, bus_if.host_gnt}, 32'd0);
      tick();
      chk("t3 no rvalid in run", {31'd0, bus_if.host_rvalid}, 32'd0);
    end
    bus_if.mem_we = 1'b0;
    chk("t2 irq", {31'd0, irq}, 32'd1);
    chk("t2 err_short", {31'd0, err_short}, 32'd0);
    chk("t2 digest_cnt", {28'd0, digest_cnt}, 32'd8);
    chk("t2 run_cycles", run_cycles, 32'd28);
    chk("t3 gnt in done", {31'd0, bus_if.host_gnt}, 32'd1);
    bus_if.host_req = 1'b0;
    run_vec(rd(16'h0003, 32'h0000_0004));
    for (int i = 0; i < 8; i++) run_vec(rd(16'h0020 + 16'(i), 32'hA000_0000 + 32'(i)));

    // ack beats a simultaneous kick
    host_msg_addr = 16'h0055;
    host_kick = 1'b1; host_ack = 1'b1;
    tick();
    host_kick = 1'b0; host_ack = 1'b0;
    chk("ack irq", {31'd0, irq}, 32'd0);
    chk("ack kick ignored", {31'd0, eng_start}, 32'd0);
    chk("ack msg kept", {16'd0, message_addr}, 32'h0000);
    // kick ignored while engine busy
    eng_done = 1'b0;
    kick(16'h0066, 16'h0066);
    chk("busy kick ignored", {31'd0, eng_start}, 32'd0);
    eng_done = 1'b1;

    // 4: engine never leaves idle
    kick(16'h0040, 16'h0050);
    chk("t4 eng_start", {31'd0, eng_start}, 32'd1);
    chk("t4 message_addr", {16'd0, message_addr}, 32'h0040);
    chk("t4 digest_cnt cleared", {28'd0, digest_cnt}, 32'd0);
    chk("t4 run_cycles cleared", run_cycles, 32'd0);
    n = 0;
    while (!irq && n < 40) begin
      tick();
      n++;
    end
    chk("t4 timeout latency", 32'(n), 32'd16);
    chk("t4 err_timeout", {31'd0, err_timeout}, 32'd1);
    ack();
    chk("t4 flags cleared", {28'd0, irq, err_timeout, err_short, err_oob}, 32'd0);

    // 5: short digest, out-of-window writes, out-of-range host read
    kick(16'h0000, 16'h0030);
    eng_done = 1'b0;
    tick();
    for (int i = 0; i < 9; i++) begin
      // 0x2F below window, 0x30..0x36 in window, 0x38 above window
      bus_if.mem_we = 1'b1;
      bus_if.mem_addr = (i == 0) ? 16'h002F : (i == 8) ? 16'h0038 : 16'h0030 + 16'(i - 1);
      bus_if.mem_write_data = 32'hB000_0000 | {16'd0, bus_if.mem_addr};
      tick();
    end
    bus_if.mem_we = 1'b0;
    eng_done = 1'b1;
    tick();
    chk("t5 irq", {31'd0, irq}, 32'd1);
    chk("t5 err_short", {31'd0, err_short}, 32'd1);
    chk("t5 digest_cnt", {28'd0, digest_cnt}, 32'd7);
    chk("t5 err_oob before", {31'd0, err_oob}, 32'd0);
    run_vec(rd(16'h0030, 32'hB000_0030));
    run_vec(rd(16'h0038, 32'hB000_0038));
    run_vec(rd(16'h0100, 32'hDEAD_BEEF));
    chk("t5 err_oob", {31'd0, err_oob}, 32'd1);
    ack();
    chk("t5 flags cleared", {28'd0, irq, err_timeout, err_short, err_oob}, 32'd0);
    // engine write outside RUN is dropped
    bus_if.mem_we = 1'b1; bus_if.mem_addr = 16'h0001; bus_if.mem_write_data = 32'hFFFF_FFFF;
    tick();
    bus_if.mem_we = 1'b0;
    run_vec(rd(16'h0001, 32'h0000_0002));

    // 6: reset in the middle of RUN
    bus_if.mem_addr = 16'h0000;
    kick(16'h0000, 16'h0020);
    eng_done = 1'b0;
    tick();
    tick(); tick();
    chk("t6 run_cycles", run_cycles, 32'd2);
    reset_n = 1'b0;
    #1;
    chk("t6 rst run_cycles", run_cycles, 32'd0);
    chk("t6 rst flags", {27'd0, irq, eng_start, err_timeout, err_short, err_oob}, 32'd0);
    chk("t6 rst addrs", {message_addr, output_addr}, 32'd0);
    chk("t6 rst mem_read_data", bus_if.mem_read_data, 32'd0);
    eng_done = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();
    chk("t6 no irq", {31'd0, irq}, 32'd0);
    run_vec(rd(16'h0000, 32'h0000_0001));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
